// File: rtl/dma_bus_arbiter.sv
// OAM DMA engine and CPU/system bus arbiter (FF46 register, 160-byte copy into OAM).
// Optional macro DMA_BUS_CONFLICT_EN: gated CPU reads return bus_data_in instead of 8'hFF.
module dma_bus_arbiter #(
    parameter int unsigned DMA_LENGTH      = 160,
    parameter logic [15:0] REG_ADDR        = 16'hFF46,
    parameter int unsigned STARTUP_MCYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_mem_addr,
    input  logic        cpu_mem_enable,
    input  logic        cpu_mem_write,
    input  logic [7:0]  cpu_mem_data_out,
    output logic [7:0]  cpu_mem_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_data,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, STARTUP, ACTIVE} state_t;

    state_t      state;
    logic [7:0]  src_reg;
    logic [7:0]  index;
    logic [7:0]  start_cnt;

    logic        last_t;
    logic        reg_hit;
    logic        hram_hit;
    logic        reg_write;
    logic [7:0]  eff_src;
    logic [15:0] dma_addr;
    logic [7:0]  conflict_data;

    assign last_t    = (t_cycle == 2'd3);
    assign reg_hit   = (cpu_mem_addr == REG_ADDR);
    assign hram_hit  = (cpu_mem_addr >= 16'hFF80) && (cpu_mem_addr <= 16'hFFFE);
    assign reg_write = cpu_mem_enable & cpu_mem_write & reg_hit;

    // Echo RAM sources (E0-FF) fold back onto C0-DF.
    assign eff_src   = (src_reg >= 8'hE0) ? (src_reg - 8'h20) : src_reg;
    assign dma_addr  = {eff_src, 8'h00} + {8'h00, index};

`ifdef DMA_BUS_CONFLICT_EN
    assign conflict_data = bus_data_in;
`else
    assign conflict_data = 8'hFF;
`endif

    always_comb begin
        bus_addr        = cpu_mem_addr;
        bus_enable      = 1'b0;
        bus_write       = 1'b0;
        bus_data_out    = cpu_mem_data_out;
        cpu_mem_data_in = bus_data_in;
        case (state)
            IDLE: begin
                bus_enable = cpu_mem_enable & ~reg_hit;
                bus_write  = cpu_mem_enable & cpu_mem_write & ~reg_hit;
            end
            STARTUP: begin
                bus_enable = cpu_mem_enable & hram_hit;
                bus_write  = cpu_mem_enable & cpu_mem_write & hram_hit;
                if (!hram_hit) cpu_mem_data_in = conflict_data;
            end
            ACTIVE: begin
                // DMA owns the bus; HRAM reads see the bus byte, HRAM writes are dropped.
                bus_addr   = dma_addr;
                bus_enable = 1'b1;
                if (!hram_hit) cpu_mem_data_in = conflict_data;
            end
            default: ;
        endcase
        if (reg_hit) cpu_mem_data_in = src_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_reg    <= '0;
            index      <= '0;
            start_cnt  <= '0;
            dma_active <= 1'b0;
            oam_write  <= 1'b0;
            oam_addr   <= '0;
            oam_data   <= '0;
        end else begin
            oam_write <= 1'b0;
            if (last_t) begin
                case (state)
                    STARTUP: begin
                        if (start_cnt == 8'(STARTUP_MCYCLES - 1)) begin
                            state <= ACTIVE;
                            index <= '0;
                        end else begin
                            start_cnt <= start_cnt + 8'd1;
                        end
                    end
                    ACTIVE: begin
                        oam_write <= 1'b1;
                        oam_addr  <= index;
                        oam_data  <= bus_data_in;
                        if (index == 8'(DMA_LENGTH - 1)) begin
                            state      <= IDLE;
                            index      <= '0;
                            dma_active <= 1'b0;
                        end else begin
                            index <= index + 8'd1;
                        end
                    end
                    default: ;
                endcase
                // A register write overrides the sequencing above but the in-flight byte is still committed.
                if (reg_write) begin
                    src_reg    <= cpu_mem_data_out;
                    state      <= STARTUP;
                    index      <= '0;
                    start_cnt  <= '0;
                    dma_active <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Owns the system bus between the CPU and the OAM DMA engine.
- Decodes CPU accesses to the DMA register (FF46) and sequences a 160-byte copy from {src,8'h00} into OAM, one byte per M-cycle.
- Gates CPU bus accesses while a transfer is running.
- Sits between the CPU memory port and the system bus decoder; OAM has a dedicated write port.

Parameters:
- DMA_LENGTH, 160: bytes per transfer; index runs 0..DMA_LENGTH-1.
- REG_ADDR, 16'hFF46: address of the DMA source/start register.
- STARTUP_MCYCLES, 1: M-cycles between the register write and the first DMA read.

Ports:
- clk  input  1  system clock (4 MHz T-cycle clock).
- reset_n  input  1  asynchronous, active-low reset.
- t_cycle  input  2  current T-cycle within the M-cycle, from the CPU; 3 = last.
- cpu_mem_addr  input  16  CPU bus address.
- cpu_mem_enable  input  1  CPU bus access request.
- cpu_mem_write  input  1  CPU write strobe.
- cpu_mem_data_out  input  8  CPU write data.
- cpu_mem_data_in  output  8  read data returned to the CPU.
- bus_addr  output  16  system bus address.
- bus_enable  output  1  system bus access enable.
- bus_write  output  1  system bus write enable.
- bus_data_out  output  8  system bus write data.
- bus_data_in  input  8  system bus read data.
- oam_addr  output  8  OAM write index.
- oam_write  output  1  OAM write strobe, one clk wide.
- oam_data  output  8  OAM write data.
- dma_active  output  1  high from the FF46 write until the last byte is written.

Behaviour:
- Interface decision: one clock, clk; reset_n asynchronous active-low. All state clears immediately on reset_n low, independent of clk.
- Reset values:
  - state Idle; src_reg 8'h00; index 0; startup count 0.
  - dma_active 0, oam_write 0, oam_addr 0, oam_data 0.
  - bus_* mirror the CPU (combinational); cpu_mem_data_in = bus_data_in.
- Register updates: state, index and src_reg update only on the posedge with t_cycle==3. Bus outputs are combinational from state and inputs.
- Register access:
  - CPU write to REG_ADDR (cpu_mem_enable & cpu_mem_write at t_cycle==3) latches src_reg = cpu_mem_data_out and enters Startup.
  - The write is not forwarded: bus_enable=0 while cpu_mem_addr==REG_ADDR.
  - A CPU read of REG_ADDR returns src_reg and is not forwarded.
- Source mapping: effective high byte = src_reg >= 8'hE0 ? src_reg - 8'h20 : src_reg (echo RAM folds onto C000-DFFF).
- States:
  - Idle: bus passes the CPU through. dma_active=0.
  - Startup: counts STARTUP_MCYCLES M-cycles, then Active with index=0. CPU is gated and dma_active=1.
  - Active:
    - bus_addr = {eff_src, 8'h00} + index; bus_enable=1, bus_write=0 for the whole M-cycle.
    - At t_cycle==3: oam_write=1, oam_addr=index, oam_data=bus_data_in, index increments.
    - After index==DMA_LENGTH-1 is written, go to Idle; dma_active drops on that same edge.
- CPU gating (Startup/Active):
  - Accesses to FF80-FFFE (HRAM) and REG_ADDR are serviced. HRAM goes to the bus only in Startup; in Active, HRAM reads return bus_data_in of a separate HRAM path — not applicable here, so HRAM is served from the bus only in Startup.
  - All other CPU writes are dropped (no bus_write). All other CPU reads return the conflict value (see Optional Feature).
  - Simplification, fixed: in Active the DMA always owns bus_addr, and CPU HRAM accesses are serviced only when the address decoder routes FF80-FFFE off-bus. In this block that means an HRAM read returns bus_data_in unchanged and an HRAM write is dropped.
- Restart: a FF46 write during Startup or Active reloads src_reg, sets index=0 and re-enters Startup. dma_active stays 1 with no glitch. The in-flight byte of that M-cycle is still written to OAM.
- Reset mid-transfer: abort immediately. No further oam_write; OAM keeps the bytes already written.
- Wrap: index never exceeds DMA_LENGTH-1. Address arithmetic is 16-bit with no carry beyond eff_src.

Optional Feature:
- Macro: DMA_BUS_CONFLICT_EN.
- Defined: gated CPU reads return bus_data_in, i.e. the byte the DMA is fetching that M-cycle (hardware-accurate conflict).
- Undefined: gated CPU reads return 8'hFF.
- Gated writes are dropped in both cases.

Test Plan:
- Write 8'hC1 to FF46; memory C100+i = i^8'h5A -> dma_active rises; first oam_write 2 M-cycles after the write; 160 writes with oam_addr 0..159 and data i^8'h5A; dma_active falls after byte 159; read FF46 returns 8'hC1.
- Write 8'hE3 to FF46 -> bus_addr sweeps C300..C39F.
- CPU reads 8'h80 from 8000 during Active -> cpu_mem_data_in is 8'hFF (macro off) or the current DMA byte (macro on); a CPU write to C000 during Active produces no bus_write.
- Rewrite FF46=8'hD0 at index 50 -> the byte at index 50 is still written; the next oam_write has oam_addr 0 after 1 startup M-cycle, with source D000; 160 further writes follow.
- Assert reset_n low mid-Active at index 80 (between clk edges) -> dma_active and oam_write go 0 asynchronously; after release, CPU passthrough is restored and FF46 reads 8'h00.
- Idle passthrough: CPU write 8'h12 to C000 -> bus_enable=1, bus_write=1, bus_data_out=8'h12, oam_write stays 0.
